// File: rtl/lo_quadrature_divider_pkg.sv
// rtl/lo_quadrature_divider_pkg.sv - constants and state type for the LO quadrature divider
package lo_quadrature_divider_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lo_state_t;

endpackage

// File: rtl/lo_quadrature_divider.sv
// rtl/lo_quadrature_divider.sv - divide-by-2 I/Q clock generator with glitch-free enable and sideband swap
module lo_quadrature_divider
  import lo_quadrature_divider_pkg::*;
(
  input  logic i_clk_2f,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_swap,
  output logic o_clk_i,
  output logic o_clk_q,
  output logic o_running
);

  logic [SYNC_STAGES-1:0] en_sync_r;
  logic                   en_sync;
  lo_state_t              state;
  logic                   swap_r;
  logic                   i_int;
  logic                   q_int;
  logic                   boundary;

  assign en_sync  = en_sync_r[SYNC_STAGES-1];
  assign boundary = ~i_int & ~q_int;

  always_ff @(posedge i_clk_2f or posedge i_reset) begin
    if (i_reset) begin
      en_sync_r <= '0;
    end else begin
      en_sync_r <= {en_sync_r[SYNC_STAGES-2:0], i_enable};
    end
  end

  // Run and swap only change while both phase flops are low, so no runt pulse can escape.
  always_ff @(posedge i_clk_2f or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      swap_r <= 1'b0;
      i_int  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          i_int <= 1'b0;
          if (boundary) begin
            swap_r <= i_swap;
            if (en_sync) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (boundary) begin
            swap_r <= i_swap;
            if (en_sync) begin
              i_int <= ~i_int;
            end else begin
              state <= ST_IDLE;
              i_int <= 1'b0;
            end
          end else begin
            i_int <= ~i_int;
          end
        end
        default: begin
          state <= ST_IDLE;
          i_int <= 1'b0;
        end
      endcase
    end
  end

  // Half-period delayed copy of I gives the 90 degree phase at f_LO.
  always_ff @(negedge i_clk_2f or posedge i_reset) begin
    if (i_reset) begin
      q_int <= 1'b0;
    end else begin
      q_int <= i_int;
    end
  end

  assign o_clk_i   = swap_r ? q_int : i_int;
  assign o_clk_q   = swap_r ? i_int : q_int;
  assign o_running = (state == ST_RUN);

endmodule

// File: tb/tb_lo_quadrature_divider.sv
// tb/tb_lo_quadrature_divider.sv - directed self-checking bench for lo_quadrature_divider
module tb_lo_quadrature_divider;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic swap;
  logic clk_i;
  logic clk_q;
  logic running;

  int n_cmp = 0;
  int n_mis = 0;

  lo_quadrature_divider dut (
    .i_clk_2f (clk),
    .i_reset  (rst),
    .i_enable (enable),
    .i_swap   (swap),
    .o_clk_i  (clk_i),
    .o_clk_q  (clk_q),
    .o_running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; swap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({clk_i, clk_q, running} !== 3'b000) begin n_mis++; $display("FAIL reset_hold: got %b expected 000", {clk_i, clk_q, running}); end
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (running !== 1'b0) begin n_mis++; $display("FAIL start_run_early p%0d: got %b expected 0", k, running); end
    end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, running} !== 2'b01) begin n_mis++; $display("FAIL start_p3: got %b expected 01", {clk_i, running}); end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, clk_q} !== 2'b10) begin n_mis++; $display("FAIL start_p4: got %b expected 10", {clk_i, clk_q}); end
    @(negedge clk); #1;
    n_cmp++; if ({clk_i, clk_q} !== 2'b11) begin n_mis++; $display("FAIL start_q_rise: got %b expected 11", {clk_i, clk_q}); end
  endtask

  task automatic test_steady();
    logic [1:0] pat [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) @(posedge clk); else @(negedge clk);
      #1;
      n_cmp++; if ({clk_i, clk_q} !== pat[k % 4]) begin n_mis++; $display("FAIL steady step%0d: got %b expected %b", k, {clk_i, clk_q}, pat[k % 4]); end
      if (k % 2 == 0) begin
        n_cmp++; if (running !== 1'b1) begin n_mis++; $display("FAIL steady_running step%0d: got %b expected 1", k, running); end
      end
    end
  endtask

  task automatic test_swap();
    logic [1:0] tab [12] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00,
                             2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    swap = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 10) swap = 1'b0;
      if (k % 2 == 0) @(posedge clk); else @(negedge clk);
      #1;
      n_cmp++; if ({clk_i, clk_q} !== tab[k]) begin n_mis++; $display("FAIL swap step%0d: got %b expected %b", k, {clk_i, clk_q}, tab[k]); end
    end
  endtask

  task automatic test_stop();
    logic [2:0] tab [8] = '{3'b011, 3'b001, 3'b101, 3'b111, 3'b011, 3'b001, 3'b000, 3'b000};
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) @(posedge clk); else @(negedge clk);
      #1;
      n_cmp++; if ({clk_i, clk_q, running} !== tab[k]) begin n_mis++; $display("FAIL stop step%0d: got %b expected %b", k, {clk_i, clk_q, running}, tab[k]); end
    end
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) @(posedge clk); else @(negedge clk);
      #1;
      n_cmp++; if ({clk_i, clk_q, running} !== 3'b000) begin n_mis++; $display("FAIL stopped step%0d: got %b expected 000", k, {clk_i, clk_q, running}); end
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #2;
    enable = 1'b1; #2;
    enable = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) @(negedge clk); else @(posedge clk);
      #1;
      n_cmp++; if ({clk_i, clk_q, running} !== 3'b000) begin n_mis++; $display("FAIL glitch step%0d: got %b expected 000", k, {clk_i, clk_q, running}); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); #1;
    enable = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (running !== 1'b0) begin n_mis++; $display("FAIL enable_latency p%0d: got %b expected 0", k, running); end
    end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, running} !== 2'b01) begin n_mis++; $display("FAIL enable_p3: got %b expected 01", {clk_i, running}); end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, clk_q} !== 2'b10) begin n_mis++; $display("FAIL enable_p4: got %b expected 10", {clk_i, clk_q}); end
    #2;
    rst = 1'b1; #1;
    n_cmp++; if ({clk_i, clk_q, running} !== 3'b000) begin n_mis++; $display("FAIL async_reset: got %b expected 000", {clk_i, clk_q, running}); end
    @(negedge clk); #2;
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({clk_i, running} !== 2'b00) begin n_mis++; $display("FAIL restart_early p%0d: got %b expected 00", k, {clk_i, running}); end
    end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, running} !== 2'b01) begin n_mis++; $display("FAIL restart_p3: got %b expected 01", {clk_i, running}); end
    @(posedge clk); #1;
    n_cmp++; if ({clk_i, clk_q} !== 2'b10) begin n_mis++; $display("FAIL restart_p4: got %b expected 10", {clk_i, clk_q}); end
    @(negedge clk); #1;
    n_cmp++; if ({clk_i, clk_q} !== 2'b11) begin n_mis++; $display("FAIL restart_q_rise: got %b expected 11", {clk_i, clk_q}); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_swap();
    test_stop();
    test_glitch();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
